// File: rtl/bypass_ctrl_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : bypass_ctrl_unit
// Description : Operand-forwarding control for a 5-stage MIPS-32 pipeline.
//               Tracks the destination register of the instructions in EXE,
//               MEM and WB. Produces one-hot 4:1 bypass-mux selects for the
//               rs and rt operands of the instruction in ID. Raises a
//               single-cycle load-use stall when a load in EXE feeds ID.
// Ports       : clk        - pipeline clock, rising edge
//               rst_n      - asynchronous active-low reset
//               ins        - IF_ID instruction word
//               ins_valid  - ins is a real instruction (0 = bubble)
//               flush      - ID instruction squashed, enters EXE as bubble
//               pipe_hold  - global freeze of the tracking registers
//               sig_a      - rs mux select (0001 RF, 0010 EXE, 0100 MEM, 1000 WB)
//               sig_b      - rt mux select (same encoding)
//               stall      - hold PC/IF_ID, insert bubble into EXE
//               stall_cnt  - saturating count of stall cycles since reset
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module bypass_ctrl_unit #(
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int LOAD_STALL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      ins,
  input  logic             ins_valid,
  input  logic             flush,
  input  logic             pipe_hold,
  output logic [3:0]       sig_a,
  output logic [3:0]       sig_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_fn_jr    = 6'b001000;

  localparam logic [3:0] c_sel_rf  = 4'b0001;
  localparam logic [3:0] c_sel_exe = 4'b0010;
  localparam logic [3:0] c_sel_mem = 4'b0100;
  localparam logic [3:0] c_sel_wb  = 4'b1000;

  // Decode of the ID instruction
  logic [5:0]        w_op;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_dst;
  logic              w_wen;
  logic              w_ld;
  logic              w_unused;

  assign w_op     = ins[31:26];
  assign w_funct  = ins[5:0];
  assign w_rs     = REG_AW'(ins[25:21]);
  assign w_rt     = REG_AW'(ins[20:16]);
  assign w_rd     = REG_AW'(ins[15:11]);
  assign w_unused = ^ins[10:6];

  always_comb begin
    w_dst = '0;
    w_wen = 1'b0;
    w_ld  = 1'b0;
    if (w_op == c_op_rtype) begin
      w_dst = w_rd;
      w_wen = (w_funct != c_fn_jr);
    end else if (w_op[5:3] == 3'b001) begin
      // addi, addiu, slti, sltiu, andi, ori, xori, lui
      w_dst = w_rt;
      w_wen = 1'b1;
    end else if (w_op == c_op_lw) begin
      w_dst = w_rt;
      w_wen = 1'b1;
      w_ld  = 1'b1;
    end else if (w_op == c_op_jal) begin
      w_dst = REG_AW'(5'd31);
      w_wen = 1'b1;
    end
    // $0 is hard-wired; a write to it never produces forwardable data
    if (w_dst == '0) begin
      w_wen = 1'b0;
      w_ld  = 1'b0;
    end
  end

  // Tracking registers for EXE, MEM, WB
  logic [REG_AW-1:0] r_exe_dst, r_mem_dst, r_wb_dst;
  logic              r_exe_wen, r_mem_wen, r_wb_wen;
  logic              r_exe_ld,  r_mem_ld,  r_wb_ld;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_stall;
  logic              w_bubble;

  assign w_bubble = !ins_valid || flush || w_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exe_dst <= '0;
      r_exe_wen <= 1'b0;
      r_exe_ld  <= 1'b0;
      r_mem_dst <= '0;
      r_mem_wen <= 1'b0;
      r_mem_ld  <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_wen  <= 1'b0;
      r_wb_ld   <= 1'b0;
    end else if (!pipe_hold) begin
      r_wb_dst  <= r_mem_dst;
      r_wb_wen  <= r_mem_wen;
      r_wb_ld   <= r_mem_ld;
      r_mem_dst <= r_exe_dst;
      r_mem_wen <= r_exe_wen;
      r_mem_ld  <= r_exe_ld;
      r_exe_dst <= w_bubble ? '0 : w_dst;
      r_exe_wen <= w_bubble ? 1'b0 : w_wen;
      r_exe_ld  <= w_bubble ? 1'b0 : w_ld;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (!pipe_hold && w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  // Load-use: the loaded value only exists after MEM, so ID must wait a cycle
  assign w_stall = (LOAD_STALL != 0) && ins_valid && !flush &&
                   r_exe_wen && r_exe_ld && (r_exe_dst != '0) &&
                   ((r_exe_dst == w_rs) || (r_exe_dst == w_rt));

  // Per-operand select, youngest producer wins
  logic [REG_AW-1:0] w_src [2];
  logic [3:0]        w_sel [2];

  assign w_src[0] = w_rs;
  assign w_src[1] = w_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_sel
    always_comb begin
      w_sel[gi] = c_sel_rf;
      if (w_src[gi] == '0) begin
        w_sel[gi] = c_sel_rf;
      end else if (r_exe_wen && (r_exe_dst == w_src[gi]) && !r_exe_ld) begin
        w_sel[gi] = c_sel_exe;
      end else if (r_exe_wen && (r_exe_dst == w_src[gi]) && w_stall) begin
        // ID is squashed and re-evaluated next cycle; value irrelevant
        w_sel[gi] = c_sel_rf;
      end else if (r_mem_wen && (r_mem_dst == w_src[gi])) begin
        w_sel[gi] = c_sel_mem;
      end else if (r_wb_wen && (r_wb_dst == w_src[gi])) begin
        w_sel[gi] = c_sel_wb;
      end
    end
  end

  assign sig_a     = w_sel[0];
  assign sig_b     = w_sel[1];
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bypass_ctrl_unit.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_bypass_ctrl_unit
// Description : Directed-vector bench for bypass_ctrl_unit with hand-computed
//               selects, stall and stall-counter values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_bypass_ctrl_unit;

  localparam int c_cnt_w = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [31:0]        ins;
  logic               ins_valid;
  logic               flush;
  logic               pipe_hold;
  logic [3:0]         sig_a;
  logic [3:0]         sig_b;
  logic               stall;
  logic [c_cnt_w-1:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  bypass_ctrl_unit #(
    .REG_AW    (5),
    .CNT_W     (c_cnt_w),
    .LOAD_STALL(1)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ins      (ins),
    .ins_valid(ins_valid),
    .flush    (flush),
    .pipe_hold(pipe_hold),
    .sig_a    (sig_a),
    .sig_b    (sig_b),
    .stall    (stall),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [5:0] c_add = 6'b100000;
  localparam logic [5:0] c_sub = 6'b100010;
  localparam logic [5:0] c_or  = 6'b100101;
  localparam logic [5:0] c_and = 6'b100100;
  localparam logic [5:0] c_xor = 6'b100110;
  localparam logic [5:0] c_addi = 6'b001000;
  localparam logic [5:0] c_lw   = 6'b100011;
  localparam logic [5:0] c_sw   = 6'b101011;

  // Drive ID inputs (called #1 after a rising edge), settle for checks
  task automatic apply(input logic [31:0] i, input logic v, input logic f, input logic h);
    ins       = i;
    ins_valid = v;
    flush     = f;
    pipe_hold = h;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sel(input string tag, input logic [3:0] ea, input logic [3:0] eb);
    check_val({tag, "_a"}, 32'(sig_a), 32'(ea));
    check_val({tag, "_b"}, 32'(sig_b), 32'(eb));
  endtask

  task automatic drain();
    apply(32'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    apply(32'd0, 1'b0, 1'b0, 1'b0);
    #2;
    check_sel("reset_sel", 4'b0001, 4'b0001);
    check_val("reset_stall", 32'(stall), 32'd0);
    check_val("reset_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;

    // Back-to-back ALU dependencies
    apply(rtype(5'd1, 5'd2, 5'd3, c_add), 1'b1, 1'b0, 1'b0);
    check_sel("add_first", 4'b0001, 4'b0001);
    tick();
    apply(rtype(5'd3, 5'd3, 5'd4, c_sub), 1'b1, 1'b0, 1'b0);
    check_sel("sub_exe", 4'b0010, 4'b0010);
    tick();
    apply(rtype(5'd3, 5'd0, 5'd5, c_or), 1'b1, 1'b0, 1'b0);
    check_sel("or_mem", 4'b0100, 4'b0001);
    tick();
    apply(rtype(5'd3, 5'd3, 5'd6, c_and), 1'b1, 1'b0, 1'b0);
    check_sel("and_wb", 4'b1000, 4'b1000);
    tick();
    apply(rtype(5'd3, 5'd3, 5'd7, c_xor), 1'b1, 1'b0, 1'b0);
    check_sel("xor_rf", 4'b0001, 4'b0001);
    tick();
    drain();

    // Load-use
    apply(itype(c_lw, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
    check_val("lw_nostall", 32'(stall), 32'd0);
    tick();
    apply(rtype(5'd8, 5'd2, 5'd9, c_add), 1'b1, 1'b0, 1'b0);
    check_val("lu_stall", 32'(stall), 32'd1);
    check_val("lu_cnt0", 32'(stall_cnt), 32'd0);
    tick();
    exp_cnt = 1;
    check_val("lu_stall_gone", 32'(stall), 32'd0);
    check_val("lu_cnt1", 32'(stall_cnt), 32'(exp_cnt));
    check_sel("lu_mem", 4'b0100, 4'b0001);
    tick();
    drain();

    // Youngest producer wins
    apply(rtype(5'd1, 5'd2, 5'd3, c_add), 1'b1, 1'b0, 1'b0);
    tick();
    apply(itype(c_addi, 5'd1, 5'd3, 16'd7), 1'b1, 1'b0, 1'b0);
    tick();
    apply(rtype(5'd3, 5'd3, 5'd4, c_add), 1'b1, 1'b0, 1'b0);
    check_sel("prio_young", 4'b0010, 4'b0010);
    tick();
    drain();

    // Register $0
    apply(itype(c_addi, 5'd1, 5'd0, 16'd5), 1'b1, 1'b0, 1'b0);
    tick();
    apply(rtype(5'd0, 5'd0, 5'd2, c_add), 1'b1, 1'b0, 1'b0);
    check_sel("zero_src", 4'b0001, 4'b0001);
    tick();
    apply(itype(c_lw, 5'd1, 5'd0, 16'd0), 1'b1, 1'b0, 1'b0);
    tick();
    apply(itype(c_sw, 5'd1, 5'd0, 16'd4), 1'b1, 1'b0, 1'b0);
    check_val("zero_lw_stall", 32'(stall), 32'd0);
    tick();
    drain();

    // Flush beats load-use stall; flushed instruction becomes a bubble
    apply(itype(c_lw, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
    tick();
    apply(rtype(5'd8, 5'd2, 5'd9, c_add), 1'b1, 1'b1, 1'b0);
    check_val("flush_stall", 32'(stall), 32'd0);
    tick();
    apply(rtype(5'd8, 5'd2, 5'd9, c_add), 1'b1, 1'b0, 1'b0);
    check_val("flush_bubble_stall", 32'(stall), 32'd0);
    check_sel("flush_bubble", 4'b0100, 4'b0001);
    check_val("flush_cnt", 32'(stall_cnt), 32'(exp_cnt));
    tick();
    // EXE=add($9), MEM=bubble, WB=lw($8)
    apply(rtype(5'd9, 5'd8, 5'd11, c_or), 1'b1, 1'b0, 1'b1);
    check_sel("hold_pre", 4'b0010, 4'b1000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_sel("hold_sel", 4'b0010, 4'b1000);
    end
    apply(rtype(5'd9, 5'd8, 5'd11, c_or), 1'b1, 1'b0, 1'b0);
    tick();
    check_sel("hold_release", 4'b0100, 4'b0001);
    drain();

    // pipe_hold during a load-use stall freezes the counter
    apply(itype(c_lw, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
    tick();
    apply(rtype(5'd2, 5'd8, 5'd9, c_add), 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("hold_stall", 32'(stall), 32'd1);
      check_val("hold_cnt", 32'(stall_cnt), 32'(exp_cnt));
    end
    apply(rtype(5'd2, 5'd8, 5'd9, c_add), 1'b1, 1'b0, 1'b0);
    tick();
    exp_cnt++;
    check_val("hold_rel_cnt", 32'(stall_cnt), 32'(exp_cnt));
    check_sel("hold_rel_sel", 4'b0001, 4'b0100);
    drain();

    // Counter saturation at 2^c_cnt_w-1
    for (int k = 0; k < 8; k++) begin
      apply(itype(c_lw, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
      tick();
      apply(rtype(5'd8, 5'd8, 5'd9, c_add), 1'b1, 1'b0, 1'b0);
      check_val("sat_stall", 32'(stall), 32'd1);
      tick();
      if (exp_cnt < 7) exp_cnt++;
      check_val("sat_cnt", 32'(stall_cnt), 32'(exp_cnt));
    end
    drain();

    // Asynchronous reset mid-stall
    apply(itype(c_lw, 5'd1, 5'd8, 16'd0), 1'b1, 1'b0, 1'b0);
    tick();
    apply(rtype(5'd8, 5'd8, 5'd9, c_add), 1'b1, 1'b0, 1'b0);
    check_val("pre_rst_stall", 32'(stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_sel("mid_rst_sel", 4'b0001, 4'b0001);
    check_val("mid_rst_stall", 32'(stall), 32'd0);
    check_val("mid_rst_cnt", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_val("post_rst_cnt", 32'(stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
